// File: rtl/router_pkg.sv
// Shared router definitions: default geometry of the output VC buffer and the flit type.
package router_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_NUM_VC     = 2;
    localparam int DEF_VC_DEPTH   = 2;

    typedef logic [DEF_DATA_WIDTH-1:0] flit_t;

endpackage

// File: rtl/router_output_vc_buffer_if.sv
// Flit ingress, drain handshake and status signals of the output VC buffer.
interface router_output_vc_buffer_if
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_VC     = DEF_NUM_VC
);
    localparam int VC_W = $clog2(NUM_VC);

    logic                  polarity;
    logic                  valid_in;
    logic [VC_W-1:0]       vc_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ready;
    logic [NUM_VC-1:0]     blocked;
    logic                  drop;
    logic                  send;
    logic [VC_W-1:0]       vc_out;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output polarity, valid_in, vc_in, data_in, ready,
        input  blocked, drop, send, vc_out, data_out
    );

    modport slave (
        input  polarity, valid_in, vc_in, data_in, ready,
        output blocked, drop, send, vc_out, data_out
    );

endinterface

// File: rtl/router_vc_fifo.sv
// Single virtual-channel FIFO with an explicit occupancy counter, so any payload value is legal.
module router_vc_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic                  do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr_reg];

    // Payload storage carries no reset; validity lives entirely in count_reg.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/router_output_vc_buffer.sv
// Output VC buffer: polarity splits VCs into a write half and a drain half; drain is round-robin.
module router_output_vc_buffer
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_VC     = DEF_NUM_VC,
    parameter int VC_DEPTH   = DEF_VC_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    router_output_vc_buffer_if.slave  bus
);
    localparam int VC_W = $clog2(NUM_VC);

    logic [NUM_VC-1:0]     writable, readable, full, empty, push, pop;
    logic [DATA_WIDTH-1:0] head [NUM_VC];
    logic                  accept;
    logic                  found;
    logic [VC_W-1:0]       sel;
    logic [VC_W-1:0]       rr_ptr_reg, rr_ptr_next;
    logic                  drop_reg;

    assign accept = bus.valid_in & writable[bus.vc_in] & ~full[bus.vc_in];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
            // Even VCs are written while polarity=1, odd VCs while polarity=0.
            assign writable[gi] = bus.polarity ^ (gi % 2 == 1);
            assign readable[gi] = ~writable[gi];
            assign push[gi]     = accept && (bus.vc_in == VC_W'(gi));
            assign pop[gi]      = bus.send && (sel == VC_W'(gi));

            router_vc_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (VC_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .push      (push[gi]),
                .push_data (bus.data_in),
                .pop       (pop[gi]),
                .full      (full[gi]),
                .empty     (empty[gi]),
                .head      (head[gi])
            );
        end
    endgenerate

    // Search starts one past the last served VC; offset NUM_VC wraps back onto rr_ptr itself.
    always_comb begin
        logic [VC_W-1:0] cand;
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_VC; k++) begin
            cand = rr_ptr_reg + VC_W'(k);
            if (!found && readable[cand] && !empty[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign bus.send     = bus.ready & found;
    assign bus.vc_out   = bus.send ? sel : '0;
    assign bus.data_out = bus.send ? head[sel] : '0;
    assign bus.blocked  = full;
    assign bus.drop     = drop_reg;

    assign rr_ptr_next = bus.send ? sel : rr_ptr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_reg <= VC_W'(NUM_VC - 1);
            drop_reg   <= 1'b0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            drop_reg   <= bus.valid_in & ~accept;
        end
    end

endmodule
